mul_seq_ctrl: RTL

- Sequencer that computes a WIDTH x WIDTH unsigned product by reusing one combinational 2x2-bit array multiplier cell over several cycles.
- Splits the operands into 2-bit digits and walks every digit pair. Each 4-bit partial product is shifted into place and accumulated.
- Sits between a requesting datapath (start/done handshake) and the shared 2x2 multiplier resource, so wider multiplies need no wider array.

---
 rtl/mul_seq_pkg.sv | 17 +
 rtl/mul2x2_cell.sv | 26 ++
 rtl/mul_seq_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the digit-serial multiply sequencer.
// Operands are processed as base-4 digits fed one pair at a time to a 2x2 cell.
package mul_seq_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digit_count(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/mul2x2_cell.sv
// Combinational 2x2-bit unsigned array multiplier: four AND partial products
// reduced by two half adders.
module mul2x2_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic pp00, pp01, pp10, pp11;
    logic s1, c1;

    assign pp00 = a[0] & b[0];
    assign pp01 = a[1] & b[0];
    assign pp10 = a[0] & b[1];
    assign pp11 = a[1] & b[1];

    // Column 1 half adder; its carry feeds the column 2 half adder.
    assign s1 = pp01 ^ pp10;
    assign c1 = pp01 & pp10;

    assign p[0] = pp00;
    assign p[1] = s1;
    assign p[2] = pp11 ^ c1;
    assign p[3] = pp11 & c1;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle WIDTHxWIDTH unsigned multiplier that walks every digit pair of
// the latched operands through one shared 2x2 cell, shift-accumulating into p.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int DIGITS = digit_count(WIDTH);
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW     = 2 * WIDTH;

    if ((WIDTH % DIGIT_W) != 0 || WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("mul_seq_ctrl: WIDTH must be even and within 2..16");
    end

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic [PW-1:0]    acc;
    logic [IW-1:0]    i, j;

    logic             load, step, fin, cancel;
    logic             j_last, last;
    logic [1:0]       a_dig, b_dig;
    logic [3:0]       pp;
    logic [IW:0]      ij;
    logic [PW-1:0]    pp_sh, acc_sum;

    // Digit selection and placement of the current partial product.
    assign a_dig   = a_r[DIGIT_W*i +: DIGIT_W];
    assign b_dig   = b_r[DIGIT_W*j +: DIGIT_W];
    assign ij      = {1'b0, i} + {1'b0, j};
    assign pp_sh   = PW'(pp) << {ij, 1'b0};
    assign acc_sum = acc + pp_sh;

    assign j_last  = (j == IW'(DIGITS - 1));
    assign last    = j_last && (i == IW'(DIGITS - 1));

    mul2x2_cell u_cell (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        cancel    = 1'b0;
        unique case (state)
            IDLE: begin
                // start wins over a simultaneous abort here
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cancel    = 1'b1;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        fin       = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            i   <= '0;
            j   <= '0;
            p   <= '0;
        end else begin
            if (load) begin
                a_r <= a;
                b_r <= b;
                acc <= '0;
                i   <= '0;
                j   <= '0;
            end else if (cancel) begin
                i <= '0;
                j <= '0;
            end else if (step) begin
                acc <= acc_sum;
                if (fin) begin
                    // final pair bypasses acc so p is valid while done is high
                    p <= acc_sum;
                    i <= '0;
                    j <= '0;
                end else if (j_last) begin
                    j <= '0;
                    i <= i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
